// File: rtl/npc_ras_pkg.sv
// Shared encodings for the next-PC generator: NPCOp / BrOp codes and the
// default reset PC. Optional feature macro used by this block: NPC_PERF_EN.
package npc_ras_pkg;

  // Next-PC source select driven by the decoder.
  typedef enum logic [2:0] {
    NPC_PC4 = 3'd0,
    NPC_BR  = 3'd1,
    NPC_J   = 3'd2,
    NPC_JR  = 3'd3
  } npc_op_e;

  // Branch compare modes; all compares treat rs as signed.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } br_op_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  // Branch condition from pre-decoded compare facts; unknown modes never take.
  function automatic logic br_cond(input logic [2:0] br_op, input logic a_neg,
                                   input logic a_zero, input logic a_eq_b);
    logic r;
    r = 1'b0;
    case (br_op)
      BR_BEQ:  r = a_eq_b;
      BR_BNE:  r = !a_eq_b;
      BR_BLEZ: r = a_neg || a_zero;
      BR_BGTZ: r = !a_neg && !a_zero;
      BR_BLTZ: r = a_neg;
      BR_BGEZ: r = !a_neg;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/npc_ras_if.sv
// D-stage control bus between the decoder (master) and the next-PC
// generator (slave). Optional feature macro of this block: NPC_PERF_EN
// (its counters are plain ports on npc_ras, not part of this bus).
//
// Handshake: there is no valid/ready pair. Every D-stage field is treated
// as valid on every cycle; stall is the sole qualifier and, when high,
// freezes F_PC and the RAS while the combinational outputs stay live.
interface npc_ras_if #(
  parameter int PC_W      = 32,
  parameter int RAS_PTR_W = 2
);
  logic              stall;
  logic [PC_W-1:0]   D_PC;
  logic [2:0]        NPCOp;
  logic [2:0]        BrOp;
  logic              link;
  logic              rs_is_ra;
  logic [PC_W-1:0]   cmp_a;
  logic [PC_W-1:0]   cmp_b;
  logic [25:0]       IR26;
  logic [PC_W-1:0]   F_PC;
  logic [PC_W-1:0]   NPC;
  logic [PC_W-1:0]   PC8;
  logic              br_taken;
  logic [PC_W-1:0]   ras_top;
  logic              ras_miss;
  logic [RAS_PTR_W:0] ras_count;   // debug view of RAS occupancy

  modport master (
    output stall, D_PC, NPCOp, BrOp, link, rs_is_ra, cmp_a, cmp_b, IR26,
    input  F_PC, NPC, PC8, br_taken, ras_top, ras_miss, ras_count
  );

  modport slave (
    input  stall, D_PC, NPCOp, BrOp, link, rs_is_ra, cmp_a, cmp_b, IR26,
    output F_PC, NPC, PC8, br_taken, ras_top, ras_miss, ras_count
  );
endinterface

// File: rtl/npc_ras_ras_stack.sv
// Circular return-address stack. ptr is the next write slot; the top entry
// is ptr-1. Pushing when full overwrites the oldest entry, popping when
// empty is ignored. top is the raw entry; callers mask it with empty.
module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 32,
  localparam int PTR_W    = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_data,
  output logic [PC_W-1:0]  top,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;

  // Stack storage, pointer and saturating occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_W'(1);
      if (count != FULL) count <= count + (PTR_W + 1)'(1);
    end else if (pop && (count != '0)) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - (PTR_W + 1)'(1);
    end
  end

  // Read port: most recent entry sits just below the write pointer.
  always_comb begin
    top_idx = ptr - PTR_W'(1);
    top     = mem[top_idx];
    empty   = (count == '0);
  end

endmodule

// File: rtl/npc_ras.sv
// Next-PC generator for the 5-stage MIPS pipeline: owns F_PC, resolves
// D-stage branches/jumps and keeps a return-address stack for jal/jr $31.
// Optional feature: define NPC_PERF_EN to add perf_taken / perf_ras_miss
// counters.
module npc_ras
  import npc_ras_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter int              RAS_DEPTH = 4,
  parameter int              RAS_PTR_W = $clog2(RAS_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  npc_ras_if.slave    bus
`ifdef NPC_PERF_EN
  ,
  output logic [31:0] perf_taken,
  output logic [31:0] perf_ras_miss
`endif
);

  logic [PC_W-1:0] f_pc;
  logic [PC_W-1:0] pc4_f;
  logic [PC_W-1:0] pc4_d;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] j_target;
  logic            a_neg;
  logic            a_zero;
  logic            a_eq_b;
  logic            cond;
  logic [PC_W-1:0] npc;
  logic            taken;
  logic            push;
  logic            pop_req;
  logic [PC_W-1:0] stk_top;
  logic            stk_empty;
  logic [PC_W-1:0] ras_top;
  logic [RAS_PTR_W:0] stk_count;

  // Fetch PC register; stall freezes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           f_pc <= RESET_PC;
    else if (!bus.stall) f_pc <= npc;
  end

  // Branch compare and next-PC select; arithmetic wraps at PC_W bits.
  always_comb begin
    pc4_f     = f_pc + PC_W'(4);
    pc4_d     = bus.D_PC + PC_W'(4);
    br_off    = {{(PC_W - 18){bus.IR26[15]}}, bus.IR26[15:0], 2'b00};
    br_target = pc4_d + br_off;
    j_target  = {bus.D_PC[PC_W-1:28], bus.IR26, 2'b00};
    a_neg     = bus.cmp_a[PC_W-1];
    a_zero    = (bus.cmp_a == '0);
    a_eq_b    = (bus.cmp_a == bus.cmp_b);
    cond      = br_cond(bus.BrOp, a_neg, a_zero, a_eq_b);
    npc       = pc4_f;
    taken     = 1'b0;
    case (bus.NPCOp)
      NPC_BR: begin
        taken = cond;
        if (cond) npc = br_target;
      end
      NPC_J: begin
        taken = 1'b1;
        npc   = j_target;
      end
      NPC_JR: begin
        taken = 1'b1;
        npc   = bus.cmp_a;
      end
      default: begin
        taken = 1'b0;
        npc   = pc4_f;
      end
    endcase
  end

  // RAS control: jal/jalr push (jalr $31 pushes only), jr $31 pops.
  // pop_req ignores stall so ras_miss stays visible in stalled cycles.
  always_comb begin
    push    = !bus.stall && bus.link &&
              ((bus.NPCOp == NPC_J) || (bus.NPCOp == NPC_JR));
    pop_req = (bus.NPCOp == NPC_JR) && bus.rs_is_ra && !bus.link;
    ras_top = stk_empty ? '0 : stk_top;
  end

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop_req && !bus.stall),
    .push_data (bus.D_PC + PC_W'(8)),
    .top       (stk_top),
    .empty     (stk_empty),
    .count     (stk_count)
  );

  // Drive the bus outputs.
  always_comb begin
    bus.F_PC      = f_pc;
    bus.NPC       = npc;
    bus.PC8       = bus.D_PC + PC_W'(8);
    bus.br_taken  = taken;
    bus.ras_top   = ras_top;
    bus.ras_miss  = pop_req && (ras_top != bus.cmp_a);
    bus.ras_count = stk_count;
  end

`ifdef NPC_PERF_EN
  // Event counters; stalled cycles are not counted, both wrap at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_taken    <= '0;
      perf_ras_miss <= '0;
    end else if (!bus.stall) begin
      if (taken) perf_taken <= perf_taken + 32'd1;
      if (pop_req && (ras_top != bus.cmp_a)) perf_ras_miss <= perf_ras_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_ras.sv
// Directed bench for npc_ras: reset, a table of combinational NPC/branch
// vectors, and hand-written multi-cycle RAS/stall sequences. Covers the
// NPC_PERF_EN counters when that macro is defined.
module tb_npc_ras;
  import npc_ras_pkg::*;

  localparam int PC_W = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  npc_ras_if #(.PC_W(PC_W), .RAS_PTR_W(2)) bus ();

`ifdef NPC_PERF_EN
  logic [31:0] perf_taken;
  logic [31:0] perf_ras_miss;
`endif

  npc_ras #(
    .PC_W      (PC_W),
    .RESET_PC  (32'h0000_3000),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef NPC_PERF_EN
    ,
    .perf_taken    (perf_taken),
    .perf_ras_miss (perf_ras_miss)
`endif
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0]  npc_op;
    logic [2:0]  br_op;
    logic [31:0] d_pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [25:0] ir26;
    logic [31:0] exp_npc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall    = 1'b0;
    bus.D_PC     = '0;
    bus.NPCOp    = NPC_PC4;
    bus.BrOp     = BR_BEQ;
    bus.link     = 1'b0;
    bus.rs_is_ra = 1'b0;
    bus.cmp_a    = '0;
    bus.cmp_b    = '0;
    bus.IR26     = '0;
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [2:0] br, input logic [31:0] d_pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [25:0] ir,
                         input logic [31:0] npc, input logic tk);
    vec_t v;
    v.npc_op = op; v.br_op = br; v.d_pc = d_pc; v.a = a; v.b = b;
    v.ir26 = ir; v.exp_npc = npc; v.exp_taken = tk;
    vecs.push_back(v);
  endtask

  logic [31:0] exp_tops[5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    reset = 1'b1;

    // ---- Reset behaviour ----
    repeat (2) step();
    reset = 1'b0;
    step();
    step();
    check("fpc_before_reset", bus.F_PC, 32'h0000_3008);
    #2 reset = 1'b1;
    #1;
    check("fpc_async_reset", bus.F_PC, 32'h0000_3000);
    check("npc_after_reset", bus.NPC, 32'h0000_3004);
    check("ras_top_reset", bus.ras_top, 32'h0);
    check("br_taken_reset", {31'b0, bus.br_taken}, 32'h0);
    check("ras_miss_reset", {31'b0, bus.ras_miss}, 32'h0);
    check("ras_count_reset", {29'b0, bus.ras_count}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(); check("fpc_clk1", bus.F_PC, 32'h0000_3004);
    step(); check("fpc_clk2", bus.F_PC, 32'h0000_3008);
    step(); check("fpc_clk3", bus.F_PC, 32'h0000_300C);
    bus.stall = 1'b1;

    // ---- Combinational vector table, F_PC frozen at 0x300C ----
    add_vec(NPC_PC4, BR_BEQ,  32'h3010, 32'h0,        32'h0, 26'h0,       32'h3010, 1'b0);
    add_vec(NPC_BR,  BR_BEQ,  32'h3010, 32'h5,        32'h5, 26'hFFFE,    32'h300C, 1'b1);
    add_vec(NPC_BR,  BR_BGTZ, 32'h3010, 32'hFFFFFFFF, 32'h0, 26'hFFFE,    32'h3010, 1'b0);
    add_vec(NPC_BR,  BR_BNE,  32'h3010, 32'h5,        32'h6, 26'h0004,    32'h3024, 1'b1);
    add_vec(NPC_BR,  BR_BNE,  32'h3010, 32'h7,        32'h7, 26'h0004,    32'h3010, 1'b0);
    add_vec(NPC_BR,  BR_BLEZ, 32'h3010, 32'h0,        32'h9, 26'h0001,    32'h3018, 1'b1);
    add_vec(NPC_BR,  BR_BLEZ, 32'h3010, 32'h1,        32'h9, 26'h0001,    32'h3010, 1'b0);
    add_vec(NPC_BR,  BR_BGTZ, 32'h3010, 32'h1,        32'h0, 26'h0001,    32'h3018, 1'b1);
    add_vec(NPC_BR,  BR_BLTZ, 32'h3010, 32'h80000000, 32'h0, 26'h0002,    32'h301C, 1'b1);
    add_vec(NPC_BR,  BR_BLTZ, 32'h3010, 32'h0,        32'h0, 26'h0002,    32'h3010, 1'b0);
    add_vec(NPC_BR,  BR_BGEZ, 32'h3010, 32'h0,        32'h0, 26'h0003,    32'h3020, 1'b1);
    add_vec(NPC_BR,  BR_BGEZ, 32'h3010, 32'hFFFFFFFF, 32'h0, 26'h0003,    32'h3010, 1'b0);
    add_vec(NPC_J,   BR_BEQ,  32'h3020, 32'h0,        32'h1, 26'h0000C10, 32'h3040, 1'b1);
    add_vec(NPC_J,   BR_BEQ,  32'hF0000000, 32'h0,    32'h1, 26'h3FFFFFF, 32'hFFFFFFFC, 1'b1);
    add_vec(NPC_JR,  BR_BEQ,  32'h3020, 32'h12345678, 32'h0, 26'h0,       32'h12345678, 1'b1);
    add_vec(3'd5,    BR_BEQ,  32'h3020, 32'h4,        32'h4, 26'h0001,    32'h3010, 1'b0);
    add_vec(NPC_BR,  BR_BEQ,  32'hFFFFFFF8, 32'h2,    32'h2, 26'h0001,    32'h00000000, 1'b1);
    add_vec(NPC_BR,  3'd6,    32'h3010, 32'h2,        32'h2, 26'h0001,    32'h3010, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.NPCOp = vecs[i].npc_op;
      bus.BrOp  = vecs[i].br_op;
      bus.D_PC  = vecs[i].d_pc;
      bus.cmp_a = vecs[i].a;
      bus.cmp_b = vecs[i].b;
      bus.IR26  = vecs[i].ir26;
      #1;
      check($sformatf("vec%0d_npc", i), bus.NPC, vecs[i].exp_npc);
      check($sformatf("vec%0d_taken", i), {31'b0, bus.br_taken}, {31'b0, vecs[i].exp_taken});
      check($sformatf("vec%0d_pc8", i), bus.PC8, vecs[i].d_pc + 32'd8);
      check($sformatf("vec%0d_miss", i), {31'b0, bus.ras_miss}, 32'h0);
    end
    check("fpc_held_table", bus.F_PC, 32'h0000_300C);

    // ---- Jump with stall: no F_PC move, no RAS push ----
    bus.NPCOp = NPC_J; bus.D_PC = 32'h3020; bus.IR26 = 26'h0000C10; bus.link = 1'b1;
    #1;
    check("j_npc", bus.NPC, 32'h0000_3040);
    check("j_taken", {31'b0, bus.br_taken}, 32'h1);
    step();
    step();
    check("stall_fpc", bus.F_PC, 32'h0000_300C);
    check("stall_ras_count", {29'b0, bus.ras_count}, 32'h0);
    idle_inputs();

    // ---- RAS match: jal then jr $31 ----
    bus.NPCOp = NPC_J; bus.link = 1'b1; bus.D_PC = 32'h3000;
    #1;
    check("jal_pc8", bus.PC8, 32'h0000_3008);
    step();
    bus.link = 1'b0; bus.NPCOp = NPC_JR; bus.rs_is_ra = 1'b1; bus.cmp_a = 32'h3008;
    #1;
    check("match_top", bus.ras_top, 32'h0000_3008);
    check("match_count", {29'b0, bus.ras_count}, 32'h1);
    check("match_miss", {31'b0, bus.ras_miss}, 32'h0);
    check("jr_npc", bus.NPC, 32'h0000_3008);
    step();
    idle_inputs();
    #1;
    check("match_top_after", bus.ras_top, 32'h0);
    check("match_count_after", {29'b0, bus.ras_count}, 32'h0);

    // ---- RAS overflow: 5 pushes into depth 4, then 5 pops ----
    for (int i = 0; i < 5; i++) begin
      bus.NPCOp = NPC_J; bus.link = 1'b1; bus.D_PC = 32'h3000 + 32'(i) * 32'h100;
      step();
    end
    idle_inputs();
    #1;
    check("ovf_count", {29'b0, bus.ras_count}, 32'h4);
    exp_tops[0] = 32'h3408; exp_tops[1] = 32'h3308; exp_tops[2] = 32'h3208;
    exp_tops[3] = 32'h3108; exp_tops[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      bus.NPCOp = NPC_JR; bus.rs_is_ra = 1'b1;
      bus.cmp_a = (i < 4) ? exp_tops[i] : 32'h3008;
      #1;
      check($sformatf("pop%0d_top", i), bus.ras_top, exp_tops[i]);
      check($sformatf("pop%0d_miss", i), {31'b0, bus.ras_miss}, (i == 4) ? 32'h1 : 32'h0);
      step();
    end
    idle_inputs();
    #1;
    check("empty_pop_count", {29'b0, bus.ras_count}, 32'h0);
    check("empty_pop_top", bus.ras_top, 32'h0);

    // ---- Stalled mispredicted jr still shows ras_miss ----
    bus.stall = 1'b1; bus.NPCOp = NPC_JR; bus.rs_is_ra = 1'b1; bus.cmp_a = 32'h1111;
    #1;
    check("stalled_miss", {31'b0, bus.ras_miss}, 32'h1);
    step();
    idle_inputs();

    // ---- jalr $31: push only ----
    bus.NPCOp = NPC_JR; bus.link = 1'b1; bus.rs_is_ra = 1'b1;
    bus.D_PC = 32'h3500; bus.cmp_a = 32'h4000;
    #1;
    check("jalr_ra_miss", {31'b0, bus.ras_miss}, 32'h0);
    step();
    idle_inputs();
    #1;
    check("jalr_ra_top", bus.ras_top, 32'h0000_3508);
    check("jalr_ra_count", {29'b0, bus.ras_count}, 32'h1);

`ifdef NPC_PERF_EN
    // ---- Performance counters ----
    reset = 1'b1;
    #1;
    check("perf_taken_reset", perf_taken, 32'h0);
    check("perf_miss_reset", perf_ras_miss, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.NPCOp = NPC_BR; bus.BrOp = BR_BEQ; bus.D_PC = 32'h3010;
    bus.cmp_a = 32'h5; bus.cmp_b = 32'h5; bus.IR26 = 26'h0010;
    repeat (3) step();
    bus.stall = 1'b1;
    step();
    bus.stall = 1'b0;
    bus.NPCOp = NPC_JR; bus.rs_is_ra = 1'b1; bus.cmp_a = 32'h1234;
    step();
    idle_inputs();
    #1;
    check("perf_taken", perf_taken, 32'd4);
    check("perf_ras_miss", perf_ras_miss, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
